// File: rtl/inst_encoder_writer.sv
// Packs field-level RV32I instructions into 32-bit words and writes them to consecutive imem words.
// Optional ENC_READBACK_CHECK_EN adds a read-back verify pass (RD/CMP states) and err_verify.
module inst_encoder_writer #(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0,
    parameter int DEPTH     = 256,
    localparam int CW       = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        fmt,
    input  logic [6:0]        opcode,
    input  logic [2:0]        fun3,
    input  logic [6:0]        fun7,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [31:0]       imm,
    output logic              imem_w_en,
    output logic [ADDR_W-1:0] imem_w_addr,
    output logic [31:0]       imem_w_data,
`ifdef ENC_READBACK_CHECK_EN
    output logic              imem_r_en,
    output logic [ADDR_W-1:0] imem_r_addr,
    input  logic [31:0]       imem_r_data,
    output logic              err_verify,
`endif
    output logic [CW-1:0]     count,
    output logic              full,
    output logic              err_fmt,
    output logic              err_align,
    output logic              err_range
);

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    typedef enum logic [2:0] {
        IDLE,
        ENC,
        WR,
        RD,
        CMP
    } state_e;

    state_e        state_q, state_d;
    logic [2:0]    fmt_q, fmt_d;
    logic [6:0]    op_q, op_d;
    logic [2:0]    fun3_q, fun3_d;
    logic [6:0]    fun7_q, fun7_d;
    logic [4:0]    rd_q, rd_d;
    logic [4:0]    rs1_q, rs1_d;
    logic [4:0]    rs2_q, rs2_d;
    logic [31:0]   imm_q, imm_d;
    logic [31:0]   word_q, word_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          err_fmt_q, err_fmt_d;
    logic          err_align_q, err_align_d;
    logic          err_range_q, err_range_d;
    logic          err_verify_q, err_verify_d;

    logic [31:0]   enc_word;
    logic          bad_fmt, bad_align, bad_range;
    logic [ADDR_W-1:0] cur_addr;

    always_comb begin
        enc_word  = '0;
        bad_fmt   = 1'b0;
        bad_align = 1'b0;
        bad_range = 1'b0;
        case (fmt_q)
            FMT_R: enc_word = {fun7_q, rs2_q, rs1_q, fun3_q, rd_q, op_q};
            FMT_I: begin
                enc_word  = {imm_q[11:0], rs1_q, fun3_q, rd_q, op_q};
                bad_range = (imm_q[31:11] != '0) && (imm_q[31:11] != '1);
            end
            FMT_S: begin
                enc_word  = {imm_q[11:5], rs2_q, rs1_q, fun3_q, imm_q[4:0], op_q};
                bad_range = (imm_q[31:11] != '0) && (imm_q[31:11] != '1);
            end
            FMT_B: begin
                enc_word  = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, fun3_q,
                             imm_q[4:1], imm_q[11], op_q};
                bad_align = imm_q[0];
                bad_range = (imm_q[31:12] != '0) && (imm_q[31:12] != '1);
            end
            FMT_U: begin
                enc_word  = {imm_q[31:12], rd_q, op_q};
                bad_range = (imm_q[11:0] != '0);
            end
            FMT_J: begin
                enc_word  = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12], rd_q, op_q};
                bad_align = imm_q[0];
                bad_range = (imm_q[31:20] != '0) && (imm_q[31:20] != '1);
            end
            default: bad_fmt = 1'b1;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        fmt_d        = fmt_q;
        op_d         = op_q;
        fun3_d       = fun3_q;
        fun7_d       = fun7_q;
        rd_d         = rd_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        imm_d        = imm_q;
        word_d       = word_q;
        count_d      = count_q;
        full_d       = full_q;
        err_fmt_d    = err_fmt_q;
        err_align_d  = err_align_q;
        err_range_d  = err_range_q;
        err_verify_d = err_verify_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    fmt_d   = fmt;
                    op_d    = opcode;
                    fun3_d  = fun3;
                    fun7_d  = fun7;
                    rd_d    = rd;
                    rs1_d   = rs1;
                    rs2_d   = rs2;
                    imm_d   = imm;
                    state_d = ENC;
                end
            end
            ENC: begin
                // Only the highest-priority failing check raises its flag
                state_d = IDLE;
                if (bad_fmt) begin
                    err_fmt_d = 1'b1;
                end else if (bad_align) begin
                    err_align_d = 1'b1;
                end else if (bad_range) begin
                    err_range_d = 1'b1;
                end else begin
                    word_d  = enc_word;
                    state_d = WR;
                end
            end
`ifdef ENC_READBACK_CHECK_EN
            WR:  state_d = RD;
            RD:  state_d = CMP;
            CMP: begin
                if (imem_r_data != word_q) begin
                    err_verify_d = 1'b1;
                end
                count_d = count_q + CW'(1);
                full_d  = (count_q == CW'(DEPTH - 1));
                state_d = IDLE;
            end
`else
            WR: begin
                count_d = count_q + CW'(1);
                full_d  = (count_q == CW'(DEPTH - 1));
                state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
        if (clr) begin
            state_d      = IDLE;
            count_d      = '0;
            full_d       = 1'b0;
            err_fmt_d    = 1'b0;
            err_align_d  = 1'b0;
            err_range_d  = 1'b0;
            err_verify_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            fmt_q        <= '0;
            op_q         <= '0;
            fun3_q       <= '0;
            fun7_q       <= '0;
            rd_q         <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            imm_q        <= '0;
            word_q       <= '0;
            count_q      <= '0;
            full_q       <= 1'b0;
            err_fmt_q    <= 1'b0;
            err_align_q  <= 1'b0;
            err_range_q  <= 1'b0;
            err_verify_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fmt_q        <= fmt_d;
            op_q         <= op_d;
            fun3_q       <= fun3_d;
            fun7_q       <= fun7_d;
            rd_q         <= rd_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            imm_q        <= imm_d;
            word_q       <= word_d;
            count_q      <= count_d;
            full_q       <= full_d;
            err_fmt_q    <= err_fmt_d;
            err_align_q  <= err_align_d;
            err_range_q  <= err_range_d;
            err_verify_q <= err_verify_d;
        end
    end

    // Gating with reset keeps in_ready low while reset is held; clr aborts a write in flight
    assign in_ready    = reset && (state_q == IDLE) && !full_q;
    assign cur_addr    = ADDR_W'(BASE_ADDR) + ADDR_W'({count_q, 2'b00});
    assign imem_w_en   = (state_q == WR) && !clr;
    assign imem_w_addr = cur_addr;
    assign imem_w_data = word_q;
    assign count       = count_q;
    assign full        = full_q;
    assign err_fmt     = err_fmt_q;
    assign err_align   = err_align_q;
    assign err_range   = err_range_q;
`ifdef ENC_READBACK_CHECK_EN
    assign imem_r_en   = (state_q == RD) && !clr;
    assign imem_r_addr = cur_addr;
    assign err_verify  = err_verify_q;
`else
    logic unused_verify;
    assign unused_verify = err_verify_q ^ err_verify_d;
`endif

endmodule
